// File: rtl/fwd_ctl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks EX/MEM/WB register writes and registers the EX operand selects.
module fwd_ctl #(
  parameter int REG_BITS = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rX,
  input  logic [REG_BITS-1:0] id_rY,
  input  logic                id_use_X,
  input  logic                id_use_Y,
  input  logic                id_wr_en,
  input  logic [REG_BITS-1:0] id_wr_reg,
  input  logic                id_is_load,
  input  logic                flush,
  input  logic                mem_stall,
  output logic [1:0]          fwd_X,
  output logic [1:0]          fwd_Y,
  output logic                stall_id,
  output logic [CNT_BITS-1:0] stall_cnt
);

  typedef struct packed {
    logic                v;
    logic [REG_BITS-1:0] wr_reg;
    logic                is_load;
  } slot_t;

  typedef enum logic [1:0] {
    SEL_PASS = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_WB   = 2'b10
  } sel_e;

  slot_t               r_ex, r_mem, r_wb;
  sel_e                r_fwd_x, r_fwd_y;
  logic [CNT_BITS-1:0] r_stall_cnt;

  logic w_x_ex, w_x_mem, w_x_wb;
  logic w_y_ex, w_y_mem, w_y_wb;
  logic w_load_use;
  sel_e w_sel_x, w_sel_y;
  logic w_unused;

  function automatic logic hit(input slot_t s, input logic valid, input logic use_s,
                               input logic [REG_BITS-1:0] rs);
    return valid & use_s & s.v & (s.wr_reg == rs);
  endfunction

  // Youngest producer wins; a WB hit needs no mux because the regfile
  // already bypasses a same-cycle write to its read port.
  function automatic sel_e resolve(input logic h_ex, input logic h_mem, input logic h_wb);
    if (h_ex)       return SEL_MEM;
    else if (h_mem) return SEL_WB;
    else if (h_wb)  return SEL_PASS;
    return SEL_PASS;
  endfunction

  always_comb begin
    w_x_ex     = hit(r_ex,  id_valid, id_use_X, id_rX);
    w_x_mem    = hit(r_mem, id_valid, id_use_X, id_rX);
    w_x_wb     = hit(r_wb,  id_valid, id_use_X, id_rX);
    w_y_ex     = hit(r_ex,  id_valid, id_use_Y, id_rY);
    w_y_mem    = hit(r_mem, id_valid, id_use_Y, id_rY);
    w_y_wb     = hit(r_wb,  id_valid, id_use_Y, id_rY);
    w_load_use = r_ex.is_load & (w_x_ex | w_y_ex);
    w_sel_x    = resolve(w_x_ex, w_x_mem, w_x_wb);
    w_sel_y    = resolve(w_y_ex, w_y_mem, w_y_wb);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and wins over mem_stall/flush;
    // all state is a handful of flops, so every bit gets a reset value.
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_fwd_x     <= SEL_PASS;
      r_fwd_y     <= SEL_PASS;
      r_stall_cnt <= '0;
    end else if (!mem_stall) begin
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_load_use || flush) begin
        r_ex    <= '0;
        r_fwd_x <= SEL_PASS;
        r_fwd_y <= SEL_PASS;
      end else begin
        r_ex    <= '{v: id_valid & id_wr_en, wr_reg: id_wr_reg, is_load: id_is_load};
        r_fwd_x <= w_sel_x;
        r_fwd_y <= w_sel_y;
      end
      if (w_load_use && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
    end
  end

  assign fwd_X     = r_fwd_x;
  assign fwd_Y     = r_fwd_y;
  assign stall_id  = mem_stall | w_load_use;
  assign stall_cnt = r_stall_cnt;

  // Load flags past EX are carried only for waveform visibility.
  assign w_unused = &{1'b0, r_mem.is_load, r_wb.is_load};

endmodule
